mem_responder: RTL

//  Memory-side responder for the req/wr/addr/rdy handshake driven by sys.

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/mem_array.sv | 29 ++
 rtl/mem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder block: FSM states,
// default access latencies and the statistics counter width.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_RD_LAT = 2;
  localparam int DEF_WR_LAT = 5;
  localparam int CNT_W      = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x DATA_W. The read register only
// loads on re_i, so it holds the last read word between reads.
module mem_array #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 13
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read or write per req/rdy handshake,
// waits a fixed per-type latency, then pulses rdy (with err on bad address).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int DEPTH_LOG2 = 13,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int WR_LAT     = DEF_WR_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy,
  output logic              err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output state_e            state_dbg
);

  // Handshake: req is a valid held with wr/addr/wdata until the one-cycle rdy
  // pulse; the request is sampled only in IDLE, and the initiator may present
  // the next request in the cycle right after rdy.

  localparam int LAT_W = $clog2(max_int(RD_LAT, WR_LAT) + 1);
  localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WR_LAT - 1);

  generate
    if (RD_LAT < 1 || WR_LAT < 1) begin : g_bad_lat
      $error("mem_responder: RD_LAT and WR_LAT must both be >= 1");
    end
  endgenerate

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  wr_q, wr_d;
  logic                  oor_q, oor_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_W-1:0]     mem_rdata;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    wr_d     = wr_q;
    oor_d    = oor_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalid_d = rvalid_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          wr_d    = wr;
          addr_d  = addr[DEPTH_LOG2-1:0];
          wdata_d = wdata;
          oor_d   = |addr[ADDR_W-1:DEPTH_LOG2];
          lat_d   = wr ? WR_LOAD : RD_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          // Out-of-range accesses still take full latency but never touch RAM;
          // a reset on this edge aborts the access.
          mem_we  = wr_q && !oor_q && !rst;
          mem_re  = !wr_q && !oor_q && !rst;
          if (!wr_q) begin
            rvalid_d = !oor_q;
          end
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (wr_q) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      wr_q     <= wr_d;
      oor_q    <= oor_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // rvalid_q masks the RAM read register so reset and bad-address reads show 0.
  assign rdata     = rvalid_q ? mem_rdata : '0;
  assign rdy       = (state_q == ST_RESP);
  assign err       = rdy && oor_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign state_dbg = state_q;

endmodule
